usd_cmd_responder: RTL



---
 rtl/usd_pkg.sv | 36 +++
 rtl/usd_cmd_responder_if.sv | 38 +++
 rtl/usd_crc7.sv | 32 +++
 rtl/usd_cmd_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/usd_pkg.sv
// usd_pkg: shared types and constants for the microSD card-side CMD responder.
// Holds the FSM state encoding, response type codes, CRC7 polynomial, frame
// lengths and the single-step CRC7 update used by usd_crc7.
package usd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX       = 3'd1,
    ST_CHK      = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_GAP      = 3'd4,
    ST_TX       = 3'd5,
    ST_RELEASE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_R2   = 2'b01,
    RSP_R1   = 2'b10,
    RSP_R3   = 2'b11
  } rsp_type_t;

  // x^7 + x^3 + 1 with the x^7 term implied
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int CMD_FRAME_LEN = 48;
  localparam int R2_FRAME_LEN  = 136;

  // One serial CRC7 step, MSB-first data
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
  endfunction

endpackage

// File: rtl/usd_cmd_responder_if.sv
// usd_cmd_responder_if: CMD-line pad signals plus the command/response
// handshake between the responder and card-emulation logic.
//   slave  : the responder (samples sdCmdIn/rsp*, drives everything else)
//   master : pad/host model and card-emulation logic
// Optional build macro: USD_RSP_CRC_INJECT_EN adds the crcInject request bit.
interface usd_cmd_responder_if;
  logic         sdCmdIn;
  logic         sdCmdOut;
  logic         sdCmdEn;
  logic         cmdValid;
  logic [5:0]   cmdIndex;
  logic [31:0]  cmdArg;
  logic         crcErr;
  logic         rspValid;
  logic [1:0]   rspType;
  logic [119:0] rspData;
  logic         rspDone;
  logic         busy;
`ifdef USD_RSP_CRC_INJECT_EN
  logic         crcInject;
`endif

  modport slave (
`ifdef USD_RSP_CRC_INJECT_EN
    input  crcInject,
`endif
    input  sdCmdIn, rspValid, rspType, rspData,
    output sdCmdOut, sdCmdEn, cmdValid, cmdIndex, cmdArg, crcErr, rspDone, busy
  );

  modport master (
`ifdef USD_RSP_CRC_INJECT_EN
    output crcInject,
`endif
    output sdCmdIn, rspValid, rspType, rspData,
    input  sdCmdOut, sdCmdEn, cmdValid, cmdIndex, cmdArg, crcErr, rspDone, busy
  );
endinterface

// File: rtl/usd_crc7.sv
// usd_crc7: serial CRC7 accumulator.
//   clk_i, rst_i : clock and synchronous active-high reset
//   clr_i        : restart from zero; combined with en_i the bit is folded into zero
//   en_i, bit_i  : shift one data bit in
//   crc_o        : current remainder
module usd_crc7
  import usd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);
  logic [6:0] crc_q;

  // Remainder register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= 7'd0;
    end else if (en_i) begin
      crc_q <= crc7_step(clr_i ? 7'd0 : crc_q, bit_i);
    end else if (clr_i) begin
      crc_q <= 7'd0;
    end else begin
      crc_q <= crc_q;
    end
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/usd_cmd_responder.sv
// usd_cmd_responder: card-side end of the microSD CMD line.
// Receives 48-bit host commands (start/transmission/end bits + CRC7 checked),
// reports index/argument, then sends an R1/R3 (48-bit) or R2 (136-bit) response.
//   sdClk, sysRst : clock, synchronous active-high reset
//   bus (slave)   : sdCmdIn/sdCmdOut/sdCmdEn pad, cmdValid/cmdIndex/cmdArg/crcErr,
//                   rspValid/rspType/rspData/rspDone, busy
// Parameters: NCR (2..63) idle cycles before the response, RSP_TIMEOUT cycles to
// wait for rspValid. Optional build macro USD_RSP_CRC_INJECT_EN adds crcInject.
module usd_cmd_responder
  import usd_pkg::*;
#(
  parameter int NCR         = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input logic                sdClk,
  input logic                sysRst,
  usd_cmd_responder_if.slave bus
);
  localparam logic [7:0] RX_FIRST_BIT = 8'(CMD_FRAME_LEN - 2);
  localparam logic [7:0] GAP_LAST     = 8'(NCR - 1);
  localparam logic [7:0] TMO_LAST     = 8'(RSP_TIMEOUT - 1);
  localparam logic [7:0] R1_DATA_LEN  = 8'(CMD_FRAME_LEN - 8);
  localparam logic [7:0] R2_DATA_LEN  = 8'(R2_FRAME_LEN - 8);
  localparam logic [7:0] R2_CRC_FIRST = 8'd8;  // R2 CRC skips the 8-bit header

  state_t       state_q;
  rsp_type_t    tx_type_q;
  logic [7:0]   cnt_q;
  logic [45:0]  rx_sh_q;
  logic [127:0] tx_sh_q;
  logic         inj_q, sd_out_q, sd_en_q, cmd_valid_q, crc_err_q, rsp_done_q, busy_q;
  logic [5:0]   cmd_index_q;
  logic [31:0]  cmd_arg_q;

  logic [46:0]  rx_frame_s;
  logic         rx_pass_s, rx_crc_en_s, tx_active_s, tx_crc_en_s, inj_s;
  logic [6:0]   crc_rx_s, crc_tx_s, crc_word_s;
  logic [7:0]   tx_idx_s, tx_len_s, tx_end_s;
  logic [127:0] tx_load_s;

`ifdef USD_RSP_CRC_INJECT_EN
  assign inj_s = bus.crcInject;
`else
  assign inj_s = 1'b0;
`endif

  // Frame bits 46..0 as they stand on the edge that samples the end bit
  assign rx_frame_s  = {rx_sh_q, bus.sdCmdIn};
  assign rx_pass_s   = (rx_frame_s[7:1] == crc_rx_s) && rx_frame_s[0] && rx_frame_s[46];
  assign rx_crc_en_s = ((state_q == ST_IDLE) && !bus.sdCmdIn) ||
                       ((state_q == ST_RX) && (cnt_q >= 8'd8));

  // The start bit leaves on the GAP exit edge, so that edge is TX bit 0
  assign tx_active_s = (state_q == ST_TX) || ((state_q == ST_GAP) && (cnt_q == GAP_LAST));
  assign tx_idx_s    = (state_q == ST_TX) ? cnt_q : 8'd0;
  assign tx_len_s    = (tx_type_q == RSP_R2) ? R2_DATA_LEN : R1_DATA_LEN;
  assign tx_end_s    = tx_len_s + 8'd8;
  assign tx_crc_en_s = tx_active_s && (tx_idx_s < tx_len_s) &&
                       ((tx_type_q == RSP_R1) ||
                        ((tx_type_q == RSP_R2) && (tx_idx_s >= R2_CRC_FIRST)));

  usd_crc7 u_crc_rx (.clk_i(sdClk), .rst_i(sysRst), .clr_i(state_q == ST_IDLE),
                     .en_i(rx_crc_en_s), .bit_i(bus.sdCmdIn), .crc_o(crc_rx_s));
  usd_crc7 u_crc_tx (.clk_i(sdClk), .rst_i(sysRst), .clr_i(state_q == ST_GAP),
                     .en_i(tx_crc_en_s), .bit_i(tx_sh_q[127]), .crc_o(crc_tx_s));

  // CRC field sent after the data; R3 carries all-ones instead of a CRC
  always_comb begin
    if (tx_type_q == RSP_R3) begin
      crc_word_s = 7'h7F;
    end else begin
      crc_word_s = {crc_tx_s[6:1], crc_tx_s[0] ^ inj_q};
    end
  end

  // Response header + data, MSB-aligned for shifting out
  always_comb begin
    case (bus.rspType)
      RSP_R2:  tx_load_s = {2'b00, 6'h3F, bus.rspData};
      RSP_R1:  tx_load_s = {2'b00, cmd_index_q, bus.rspData[31:0], 88'd0};
      default: tx_load_s = {2'b00, 6'h3F, bus.rspData[31:0], 88'd0};
    endcase
  end

  // Command/response FSM with registered line and status outputs
  always_ff @(posedge sdClk) begin
    if (sysRst) begin
      state_q     <= ST_IDLE;
      tx_type_q   <= RSP_NONE;
      cnt_q       <= 8'd0;
      rx_sh_q     <= 46'd0;
      tx_sh_q     <= 128'd0;
      inj_q       <= 1'b0;
      sd_out_q    <= 1'b1;
      sd_en_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      rsp_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
    end else begin
      cmd_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      rsp_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sd_out_q <= 1'b1;
          sd_en_q  <= 1'b0;
          busy_q   <= !bus.sdCmdIn;
          if (!bus.sdCmdIn) begin
            state_q <= ST_RX;
            cnt_q   <= RX_FIRST_BIT;
          end
        end
        ST_RX: begin
          rx_sh_q <= {rx_sh_q[44:0], bus.sdCmdIn};
          if (cnt_q == 8'd0) begin
            // Verdict is registered here so cmdValid/crcErr are high during CHK
            state_q <= ST_CHK;
            if (rx_pass_s) begin
              cmd_valid_q <= 1'b1;
              cmd_index_q <= rx_frame_s[45:40];
              cmd_arg_q   <= rx_frame_s[39:8];
            end else begin
              crc_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_CHK: begin
          cnt_q <= 8'd0;
          if (cmd_valid_q) begin
            state_q <= ST_WAIT_RSP;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_WAIT_RSP: begin
          if (bus.rspValid && (bus.rspType == RSP_NONE)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.rspValid) begin
            state_q   <= ST_GAP;
            tx_type_q <= rsp_type_t'(bus.rspType);
            tx_sh_q   <= tx_load_s;
            inj_q     <= inj_s;
            cnt_q     <= 8'd0;
          end else if (cnt_q == TMO_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q  <= ST_TX;
            sd_out_q <= tx_sh_q[127];
            sd_en_q  <= 1'b1;
            tx_sh_q  <= {tx_sh_q[126:0], 1'b0};
            cnt_q    <= 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_TX: begin
          if (cnt_q == tx_end_s) begin
            state_q    <= ST_RELEASE;
            sd_out_q   <= 1'b1;
            rsp_done_q <= 1'b1;
          end else if (cnt_q == tx_len_s) begin
            // CRC is complete now: send its MSB, queue the rest plus end bit
            sd_out_q <= crc_word_s[6];
            tx_sh_q  <= {crc_word_s[5:0], 1'b1, 121'd0};
            cnt_q    <= cnt_q + 8'd1;
          end else begin
            sd_out_q <= tx_sh_q[127];
            tx_sh_q  <= {tx_sh_q[126:0], 1'b0};
            cnt_q    <= cnt_q + 8'd1;
          end
        end
        ST_RELEASE: begin
          state_q  <= ST_IDLE;
          sd_out_q <= 1'b1;
          sd_en_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          sd_out_q <= 1'b1;
          sd_en_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sdCmdOut = sd_out_q;
  assign bus.sdCmdEn  = sd_en_q;
  assign bus.cmdValid = cmd_valid_q;
  assign bus.cmdIndex = cmd_index_q;
  assign bus.cmdArg   = cmd_arg_q;
  assign bus.crcErr   = crc_err_q;
  assign bus.rspDone  = rsp_done_q;
  assign bus.busy     = busy_q;
endmodule
